// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, reads the instruction ROM, resolves
// jumps locally and issues all other instructions over a valid/ready handshake.
module fetch_unit #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter logic [3:0]  JMP_OP = 4'b1100,
  parameter logic [3:0]  JZ_OP  = 4'b1101
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt_req,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              zero_flag,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] address,
  output logic              pc_enable,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [7:0]        fetch_count
);

  localparam int unsigned OP_W  = DATA_W - ADDR_W;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_BRANCH,
    S_HALTED
  } state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [DATA_W-1:0]  r_ir;
  logic [CNT_W-1:0]   r_fetch_count;

  logic [OP_W-1:0]    w_rom_op;
  logic [OP_W-1:0]    w_ir_op;
  logic [ADDR_W-1:0]  w_ir_target;
  logic [ADDR_W-1:0]  w_pc_inc;
  logic               w_rom_is_branch;
  logic               w_taken;

  assign w_rom_op        = rom_data[DATA_W-1:ADDR_W];
  assign w_ir_op         = r_ir[DATA_W-1:ADDR_W];
  assign w_ir_target     = r_ir[ADDR_W-1:0];
  assign w_pc_inc        = r_pc + ADDR_W'(1);
  assign w_rom_is_branch = (w_rom_op == JMP_OP) || (w_rom_op == JZ_OP);
  assign w_taken         = (w_ir_op == JMP_OP) || ((w_ir_op == JZ_OP) && zero_flag);

  // Control FSM together with the PC, instruction register and fetch counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_pc          <= '0;
      r_ir          <= '0;
      r_fetch_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (halt_req) begin
            r_state <= S_HALTED;
          end else begin
            r_ir <= rom_data;
            if (r_fetch_count != {CNT_W{1'b1}})
              r_fetch_count <= r_fetch_count + CNT_W'(1);
            r_state <= w_rom_is_branch ? S_BRANCH : S_ISSUE;
          end
        end
        S_ISSUE: begin
          // halt is only honoured once the pending instruction is accepted
          if (instr_ready) begin
            r_pc    <= w_pc_inc;
            r_state <= halt_req ? S_HALTED : S_FETCH;
          end
        end
        S_BRANCH: begin
          r_pc    <= w_taken ? w_ir_target : w_pc_inc;
          r_state <= S_FETCH;
        end
        S_HALTED: begin
          if (start && !halt_req) r_state <= S_FETCH;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Control outputs are pure decodes of the state register.
  assign address     = r_pc;
  assign pc          = r_pc;
  assign instr       = r_ir;
  assign fetch_count = r_fetch_count;
  assign pc_enable   = (r_state == S_FETCH);
  assign instr_valid = (r_state == S_ISSUE);
  assign halted      = (r_state == S_HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: ROM model, issue scoreboard and immediate-assert checks.
module tb_fetch_unit;

  logic       clk;
  logic       reset;
  logic       start;
  logic       halt_req;
  logic [7:0] rom_data;
  logic       zero_flag;
  logic       instr_ready;
  logic [3:0] address;
  logic       pc_enable;
  logic [7:0] instr;
  logic       instr_valid;
  logic [3:0] pc;
  logic       halted;
  logic [7:0] fetch_count;

  logic [7:0] rom [16];
  logic [7:0] exp_q [$];
  int checks;
  int failures;

  assign rom_data = rom[address];

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .halt_req    (halt_req),
    .rom_data    (rom_data),
    .zero_flag   (zero_flag),
    .instr_ready (instr_ready),
    .address     (address),
    .pc_enable   (pc_enable),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score a handshake completing at this edge, then step to the next negedge.
  task automatic cyc();
    logic [7:0] e;
    if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_issue", 32'(instr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("issue_data", 32'(instr), 32'(e));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    start = 1'b0;
    halt_req = 1'b0;
    zero_flag = 1'b0;
    instr_ready = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_pc_en", 32'(pc_enable), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);

    // Async reset while an instruction is pending
    rom[0] = 8'h1C;
    reset = 1'b1;
    cyc();
    chk("idle_no_fetch", 32'(pc_enable), 32'h0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("fetch_pc_en", 32'(pc_enable), 32'h1);
    exp_q.push_back(8'h1C);
    cyc();
    chk("pend_valid", 32'(instr_valid), 32'h1);
    chk("pend_instr", 32'(instr), 32'h1C);
    chk("pend_count", 32'(fetch_count), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", 32'(instr_valid), 32'h0);
    chk("arst_pc_en", 32'(pc_enable), 32'h0);
    chk("arst_pc", 32'(pc), 32'h0);
    chk("arst_instr", 32'(instr), 32'h0);
    chk("arst_count", 32'(fetch_count), 32'h0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post_rst_idle", 32'({pc_enable, instr_valid, halted}), 32'h0);
    end

    // Sequential issue, backpressure, branches and wrap
    rom[0] = 8'h03; rom[1] = 8'h1C; rom[2] = 8'h4F; rom[3] = 8'hC5;
    rom[5] = 8'hCE; rom[14] = 8'hDA; rom[15] = 8'h5F;
    exp_q.push_back(8'h03); exp_q.push_back(8'h1C); exp_q.push_back(8'h4F);
    exp_q.push_back(8'h5F); exp_q.push_back(8'h03);
    instr_ready = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("seq_fetch_addr", 32'(address), 32'h0);
    cyc();
    chk("seq_valid0", 32'(instr_valid), 32'h1);
    cyc();
    chk("seq_pc1", 32'(pc), 32'h1);
    cyc();
    chk("seq_valid1", 32'(instr_valid), 32'h1);
    cyc();
    chk("seq_pc2", 32'(pc), 32'h2);
    chk("seq_count2", 32'(fetch_count), 32'h2);
    cyc();
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_instr", 32'(instr), 32'h4F);
      chk("bp_valid", 32'(instr_valid), 32'h1);
      chk("bp_pc", 32'(pc), 32'h2);
      cyc();
    end
    instr_ready = 1'b1;
    cyc();
    chk("bp_release_pc", 32'(pc), 32'h3);
    chk("bp_release_fetch", 32'(pc_enable), 32'h1);
    cyc();
    chk("jmp_no_issue", 32'({instr_valid, pc_enable}), 32'h0);
    cyc();
    chk("jmp_target", 32'(address), 32'h5);
    cyc();
    cyc();
    chk("jmp14_target", 32'(address), 32'hE);
    cyc();
    chk("jz_no_issue", 32'(instr_valid), 32'h0);
    cyc();
    chk("jz_not_taken", 32'(address), 32'hF);
    cyc();
    cyc();
    chk("wrap_pc", 32'(address), 32'h0);
    chk("wrap_fetch", 32'(pc_enable), 32'h1);
    cyc();
    cyc();
    chk("after_wrap_pc", 32'(pc), 32'h1);

    // Taken JZ, backward jump, then halt behind a stalled instruction
    rom[1] = 8'hCE; rom[10] = 8'hC4; rom[4] = 8'h2A;
    zero_flag = 1'b1;
    cyc();
    cyc();
    chk("jmp_to_14", 32'(address), 32'hE);
    cyc();
    cyc();
    chk("jz_taken", 32'(address), 32'hA);
    cyc();
    chk("c4_no_issue", 32'(instr_valid), 32'h0);
    cyc();
    chk("c4_target", 32'(address), 32'h4);
    zero_flag = 1'b0;
    exp_q.push_back(8'h2A);
    cyc();
    instr_ready = 1'b0;
    halt_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("halt_hold_valid", 32'(instr_valid), 32'h1);
      chk("halt_hold_instr", 32'(instr), 32'h2A);
    end
    instr_ready = 1'b1;
    cyc();
    chk("halted_flag", 32'(halted), 32'h1);
    chk("halted_pc", 32'(pc), 32'h5);
    start = 1'b1;
    cyc();
    chk("halt_blocks_start", 32'(halted), 32'h1);
    halt_req = 1'b0;
    cyc();
    start = 1'b0;
    chk("resume_fetch", 32'(pc_enable), 32'h1);
    chk("resume_addr", 32'(address), 32'h5);

    // Saturation: 300 plain fetches from a uniform ROM
    for (int i = 0; i < 16; i++) rom[i] = 8'h11;
    for (int i = 0; i < 300; i++) begin
      exp_q.push_back(8'h11);
      cyc();
      cyc();
    end
    chk("sat_count", 32'(fetch_count), 32'hFF);
    chk("sat_pc", 32'(pc), 32'h1);
    halt_req = 1'b1;
    cyc();
    chk("fetch_halt", 32'(halted), 32'h1);
    chk("fetch_halt_count", 32'(fetch_count), 32'hFF);
    chk("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
